icache: RTL and testbench
=========================

Name: icache

Overview:
- Instruction-side responder for the fetcher's cache interface.
- Direct-mapped cache of 32-bit instruction words, indexed by halfword PC, so RV32C instructions at 2-byte alignment hit directly.
- Lookup of fet_pc is combinational: a hit returns icache_ready and icache_inst in the same cycle.
- On a miss, the block issues one 32-bit instruction read to the memory controller, holds it until mem_ready, then fills the entry. The fetcher takes mem_inst directly on that same mem_ready cycle.

Parameters:
- INDEX_BITS, 8: entries = 2^INDEX_BITS; index = pc[INDEX_BITS:1].
- TAG_BITS, `XLEN-INDEX_BITS-1: tag = pc[`XLEN-1:INDEX_BITS+1].

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global ready; when low, all state is frozen.
- flush  in  1  ROB mispredict flush.
- fet_icache_enable  in  1  fetcher lookup request.
- fet_pc  in  `XLEN  lookup address; bit 0 is ignored.
- mem_ready  in  1  memory controller ifetch data valid (one-cycle pulse).
- mem_inst  in  `XLEN  memory controller ifetch data.
- icache_ready  out  1  hit this cycle (combinational).
- icache_inst  out  `XLEN  hit data (combinational).
- icache_mem_req  out  1  ifetch request to memory controller (registered).
- icache_mem_addr  out  `XLEN  ifetch address, halfword aligned (registered).

Behaviour:
- Storage:
  - valid[2^INDEX_BITS]: flops, all cleared by rst in one cycle.
  - tag and data arrays: no reset.
- Hit:
  - icache_ready = !rst && !flush && state==IDLE && fet_icache_enable && valid[idx] && tag[idx]==fet_pc tag.
  - icache_inst = data[idx] when icache_ready is high, else 0.
- FSM states: IDLE, WAIT.
- IDLE:
  - A miss (enable && !hit && !flush) moves to WAIT next cycle.
  - On that transition: icache_mem_req<=1, icache_mem_addr<={fet_pc[`XLEN-1:1],1'b0}, and miss_pc is latched.
- WAIT:
  - icache_mem_req stays high and icache_mem_addr stays stable until mem_ready.
  - On mem_ready: write valid/tag/data for miss_pc, drop icache_mem_req, return to IDLE.
  - fet_icache_enable is ignored in WAIT; the fetcher deasserts it after a miss.
- Handshake: the request is level-held and the memory controller samples it whenever it is free. Exactly one mem_ready per request. No new request is issued while in WAIT.
- Fill-then-hit: the cycle after a fill, IDLE lookups of the same PC hit. Fill write and lookup are never in the same cycle, because the fill occurs in WAIT.
- Flush:
  - In any state, next state is IDLE and icache_mem_req<=0. The fill is not written.
  - The memory controller cancels its in-flight ifetch on the same flush and produces no mem_ready for it.
  - mem_ready coincident with flush is ignored.
  - Valid bits are untouched; the cache is not invalidated by flush.
- Priority: rst > flush > mem_ready > new miss.
- rst mid-miss: state goes to IDLE, icache_mem_req and icache_mem_addr go to 0, valid is cleared.
- Reset values: icache_mem_req=0, icache_mem_addr=0, state=IDLE. icache_ready=0 and icache_inst=0 while rst is high.
- Width rules:
  - Index and tag slices are exactly as given in Parameters.
  - PCs that alias modulo 2^(INDEX_BITS+1) bytes evict each other.
  - The fill always overwrites the entry.
- No self-modifying-code coherence: stores to instruction memory are not snooped.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- When defined:
  - Adds outputs perf_hit_cnt and perf_miss_cnt, each 32 bits, saturating at 0xFFFFFFFF, cleared on rst.
  - Hit counter increments on each icache_ready cycle.
  - Miss counter increments on each IDLE->WAIT transition.
  - Counters are frozen when rdy is low.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package / global_params additions:
  - ICACHE_INDEX_BITS default.
  - FSM state encoding: ICACHE_IDLE=1'b0, ICACHE_WAIT=1'b1.
- One sub-module, icache_array: valid/tag/data storage with a combinational read port and a synchronous write port plus clear. The FSM stays in icache.

Test Plan:
- Cold miss: after rst, enable=1, pc=0x100 -> icache_ready=0; next cycle icache_mem_req=1 with addr=0x100; mem_ready with mem_inst=0x00000513 -> req drops; next lookup of 0x100 -> ready=1, inst=0x00000513 same cycle.
- Compressed alignment: fill pc=0x102 with 0x00014501 -> hit at 0x102 returns 0x00014501; lookup 0x100 is still independent (miss if unfilled).
- Conflict eviction, INDEX_BITS=8: fill 0x000 with A, then 0x200 with B -> 0x000 misses, 0x200 hits B.
- Flush in WAIT: miss on 0x40, flush one cycle later -> next cycle icache_mem_req=0, state IDLE; 0x40 still misses afterwards; a prior hit entry 0x100 still hits.
- Reset mid-miss plus rdy stall: hold rdy=0 for 5 cycles during WAIT -> req and addr unchanged; then rst=1 -> req=0, addr=0, and all previous hits now miss.
- ICACHE_PERF_EN defined: 3 hits and 2 misses -> perf_hit_cnt=3, perf_miss_cnt=2; preload 0xFFFFFFFF and hit once -> stays 0xFFFFFFFF.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared icache definitions: XLEN default, index width, FSM encoding,
// and a saturating increment used by the optional ICACHE_PERF_EN counters.
`ifndef XLEN
`define XLEN 32
`endif

package icache_pkg;

    localparam int ICACHE_INDEX_BITS = 8;

    typedef enum logic {
        ICACHE_IDLE = 1'b0,
        ICACHE_WAIT = 1'b1
    } icache_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped icache storage: valid flops with one-cycle clear,
// tag/data memories with a combinational read and synchronous write.
import icache_pkg::*;

module icache_array #(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_BITS   = `XLEN - ICACHE_INDEX_BITS - 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [`XLEN-1:0]      rd_data,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [`XLEN-1:0]      wr_data
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;
    logic [TAG_BITS-1:0] tag_mem [ENTRIES];
    logic [`XLEN-1:0]    data_mem [ENTRIES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

    // Valid bits: clear wins over a fill in the same cycle.
    always_comb begin
        valid_d = valid_q;
        if (clr) begin
            valid_d = '0;
        end else if (we) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    // Valid register update.
    always_ff @(posedge clk) begin
        valid_q <= valid_d;
    end

    // Tag/data memories have no reset; valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (we && !clr) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped halfword-indexed instruction cache with a one-request
// miss FSM. Optional counters under `ifdef ICACHE_PERF_EN.
import icache_pkg::*;

module icache #(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_BITS   = `XLEN - INDEX_BITS - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              fet_icache_enable,
    input  logic [`XLEN-1:0]  fet_pc,
    input  logic              mem_ready,
    input  logic [`XLEN-1:0]  mem_inst,
    output logic              icache_ready,
    output logic [`XLEN-1:0]  icache_inst,
    output logic              icache_mem_req,
    output logic [`XLEN-1:0]  icache_mem_addr
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]       perf_hit_cnt,
    output logic [31:0]       perf_miss_cnt
`endif
);

    icache_state_e state_q, state_d;
    logic             req_q, req_d;
    logic [`XLEN-1:0] addr_q, addr_d;

    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [`XLEN-1:0]      rd_data;
    logic                  fill_we;
    logic                  miss_go;
    logic                  hit;

    logic [INDEX_BITS-1:0] pc_idx;
    logic [TAG_BITS-1:0]   pc_tag;
    logic [INDEX_BITS-1:0] miss_idx;
    logic [TAG_BITS-1:0]   miss_tag;

    // The latched request address doubles as the miss PC for the fill.
    assign pc_idx   = fet_pc[INDEX_BITS:1];
    assign pc_tag   = fet_pc[`XLEN-1:INDEX_BITS+1];
    assign miss_idx = addr_q[INDEX_BITS:1];
    assign miss_tag = addr_q[`XLEN-1:INDEX_BITS+1];

    logic unused_bits;
    assign unused_bits = fet_pc[0] ^ addr_q[0];

    icache_array #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_array (
        .clk     (clk),
        .clr     (rst),
        .rd_idx  (pc_idx),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .we      (fill_we),
        .wr_idx  (miss_idx),
        .wr_tag  (miss_tag),
        .wr_data (mem_inst)
    );

    assign hit = !rst && !flush && (state_q == ICACHE_IDLE) &&
                 fet_icache_enable && rd_valid && (rd_tag == pc_tag);
    assign icache_ready    = hit;
    assign icache_inst     = hit ? rd_data : '0;
    assign icache_mem_req  = req_q;
    assign icache_mem_addr = addr_q;

    // Next state: rst > flush > mem_ready > new miss; rdy low freezes all.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        fill_we = 1'b0;
        miss_go = 1'b0;
        if (rst) begin
            state_d = ICACHE_IDLE;
            req_d   = 1'b0;
            addr_d  = '0;
        end else if (rdy) begin
            if (flush) begin
                state_d = ICACHE_IDLE;
                req_d   = 1'b0;
            end else begin
                unique case (state_q)
                    ICACHE_IDLE: begin
                        if (fet_icache_enable && !hit) begin
                            miss_go = 1'b1;
                            state_d = ICACHE_WAIT;
                            req_d   = 1'b1;
                            addr_d  = {fet_pc[`XLEN-1:1], 1'b0};
                        end
                    end
                    ICACHE_WAIT: begin
                        if (mem_ready) begin
                            fill_we = 1'b1;
                            state_d = ICACHE_IDLE;
                            req_d   = 1'b0;
                        end
                    end
                    default: state_d = ICACHE_IDLE;
                endcase
            end
        end
    end

    // FSM and request registers.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        req_q   <= req_d;
        addr_q  <= addr_d;
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Saturating hit/miss counters, frozen while rdy is low.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (rst) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (rdy) begin
            if (hit) begin
                hit_cnt_d = sat_inc(hit_cnt_q);
            end
            if (miss_go) begin
                miss_cnt_d = sat_inc(miss_cnt_q);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        hit_cnt_q  <= hit_cnt_d;
        miss_cnt_q <= miss_cnt_d;
    end

    assign perf_hit_cnt  = hit_cnt_q;
    assign perf_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: table-driven lookups plus hand-written
// miss/fill, flush, stall and reset sequences.
module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        fet_icache_enable;
    logic [31:0] fet_pc;
    logic        mem_ready;
    logic [31:0] mem_inst;
    logic        icache_ready;
    logic [31:0] icache_inst;
    logic        icache_mem_req;
    logic [31:0] icache_mem_addr;

    int checks;
    int errors;

    icache dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .flush            (flush),
        .fet_icache_enable(fet_icache_enable),
        .fet_pc           (fet_pc),
        .mem_ready        (mem_ready),
        .mem_inst         (mem_inst),
        .icache_ready     (icache_ready),
        .icache_inst      (icache_inst),
        .icache_mem_req   (icache_mem_req),
        .icache_mem_addr  (icache_mem_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        en;
        logic [31:0] pc;
        logic        exp_ready;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Combinational lookup without clocking, so no miss is launched.
    task automatic look(input string name, input logic en,
                        input logic [31:0] pc, input logic er,
                        input logic [31:0] ei);
        fet_icache_enable = en;
        fet_pc = pc;
        #1;
        chk({name, "_rdy"}, {31'd0, icache_ready}, {31'd0, er});
        chk({name, "_inst"}, icache_inst, ei);
        fet_icache_enable = 1'b0;
        #1;
    endtask

    // Full miss: lookup misses, request issued, one wait cycle, fill.
    task automatic miss_fill(input string name, input logic [31:0] pc,
                             input logic [31:0] inst);
        fet_icache_enable = 1'b1;
        fet_pc = pc;
        #1;
        chk({name, "_miss"}, {31'd0, icache_ready}, 32'd0);
        step();
        fet_icache_enable = 1'b0;
        chk({name, "_req"}, {31'd0, icache_mem_req}, 32'd1);
        chk({name, "_addr"}, icache_mem_addr, pc & 32'hFFFF_FFFE);
        step();
        chk({name, "_hold"}, {31'd0, icache_mem_req}, 32'd1);
        mem_ready = 1'b1;
        mem_inst = inst;
        step();
        mem_ready = 1'b0;
        mem_inst = 32'd0;
        chk({name, "_drop"}, {31'd0, icache_mem_req}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        rdy = 1'b1;
        flush = 1'b0;
        fet_icache_enable = 1'b1;
        fet_pc = 32'h100;
        mem_ready = 1'b0;
        mem_inst = 32'd0;
        step();
        step();
        chk("rst_rdy", {31'd0, icache_ready}, 32'd0);
        chk("rst_inst", icache_inst, 32'd0);
        chk("rst_req", {31'd0, icache_mem_req}, 32'd0);
        chk("rst_addr", icache_mem_addr, 32'd0);
        fet_icache_enable = 1'b0;
        rst = 1'b0;
        step();

        look("cold", 1'b1, 32'h100, 1'b0, 32'd0);
        miss_fill("f100", 32'h100, 32'h0000_0513);
        look("hit100", 1'b1, 32'h100, 1'b1, 32'h0000_0513);
        look("hit102_unfilled", 1'b1, 32'h102, 1'b0, 32'd0);
        miss_fill("f102", 32'h102, 32'h0001_4501);
        miss_fill("f000", 32'h000, 32'h1111_1111);
        look("hit000", 1'b1, 32'h000, 1'b1, 32'h1111_1111);
        miss_fill("f200", 32'h200, 32'h2222_2222);

        vecs.push_back('{"v100",  1'b1, 32'h100,      1'b1, 32'h0000_0513});
        vecs.push_back('{"v101",  1'b1, 32'h101,      1'b1, 32'h0000_0513});
        vecs.push_back('{"v102",  1'b1, 32'h102,      1'b1, 32'h0001_4501});
        vecs.push_back('{"v104",  1'b1, 32'h104,      1'b0, 32'd0});
        vecs.push_back('{"v200",  1'b1, 32'h200,      1'b1, 32'h2222_2222});
        vecs.push_back('{"v000",  1'b1, 32'h000,      1'b0, 32'd0});
        vecs.push_back('{"vdis",  1'b0, 32'h100,      1'b0, 32'd0});
        vecs.push_back('{"v302",  1'b1, 32'h302,      1'b0, 32'd0});
        vecs.push_back('{"vhtag", 1'b1, 32'h1000_0100, 1'b0, 32'd0});
        foreach (vecs[i]) begin
            look(vecs[i].name, vecs[i].en, vecs[i].pc,
                 vecs[i].exp_ready, vecs[i].exp_inst);
        end

        // Flush while waiting: request drops, no fill.
        fet_icache_enable = 1'b1;
        fet_pc = 32'h40;
        step();
        chk("fl_req", {31'd0, icache_mem_req}, 32'd1);
        chk("fl_addr", icache_mem_addr, 32'h40);
        flush = 1'b1;
        fet_pc = 32'h100;
        #1;
        chk("fl_nohit", {31'd0, icache_ready}, 32'd0);
        step();
        flush = 1'b0;
        fet_icache_enable = 1'b0;
        chk("fl_drop", {31'd0, icache_mem_req}, 32'd0);
        look("fl_40", 1'b1, 32'h40, 1'b0, 32'd0);
        look("fl_100", 1'b1, 32'h100, 1'b1, 32'h0000_0513);

        // mem_ready coincident with flush must not fill.
        fet_icache_enable = 1'b1;
        fet_pc = 32'h60;
        step();
        fet_icache_enable = 1'b0;
        flush = 1'b1;
        mem_ready = 1'b1;
        mem_inst = 32'hDEAD_BEEF;
        step();
        flush = 1'b0;
        mem_ready = 1'b0;
        chk("flmr_req", {31'd0, icache_mem_req}, 32'd0);
        look("flmr_60", 1'b1, 32'h60, 1'b0, 32'd0);

        // Back in IDLE: a fresh miss on 0x40 completes normally.
        miss_fill("f040", 32'h40, 32'h3333_3333);
        look("hit40", 1'b1, 32'h40, 1'b1, 32'h3333_3333);

        // rdy low in IDLE blocks a new miss.
        rdy = 1'b0;
        fet_icache_enable = 1'b1;
        fet_pc = 32'h80;
        step();
        chk("stall_nomiss", {31'd0, icache_mem_req}, 32'd0);
        rdy = 1'b1;
        step();
        fet_icache_enable = 1'b0;
        chk("st_req", {31'd0, icache_mem_req}, 32'd1);
        chk("st_addr", icache_mem_addr, 32'h80);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_req", {31'd0, icache_mem_req}, 32'd1);
            chk("stall_addr", icache_mem_addr, 32'h80);
        end
        rdy = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rm_req", {31'd0, icache_mem_req}, 32'd0);
        chk("rm_addr", icache_mem_addr, 32'd0);
        look("rm_100", 1'b1, 32'h100, 1'b0, 32'd0);
        look("rm_102", 1'b1, 32'h102, 1'b0, 32'd0);
        look("rm_200", 1'b1, 32'h200, 1'b0, 32'd0);
        look("rm_40", 1'b1, 32'h40, 1'b0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
